// File: rtl/axi_pkg.sv
// Shared AXI read-path types: channel payloads, FSM state and decode targets.
package axi_pkg;

  localparam int unsigned ID_M_W = 4;
  localparam int unsigned ID_S_W = 8;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned PFX_W  = ID_S_W - ID_M_W;

  typedef struct packed {
    logic [ID_M_W-1:0] id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } ar_m_t;

  typedef struct packed {
    logic [ID_S_W-1:0] id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } ar_s_t;

  typedef struct packed {
    logic [ID_M_W-1:0] id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_m_t;

  typedef struct packed {
    logic [ID_S_W-1:0] id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_s_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} fsm_e;

  typedef enum logic [1:0] {TGT_S0, TGT_S1, TGT_SD} tgt_e;

endpackage

// File: rtl/axi_rd_decoder.sv
// Address to slave map: two 64 KiB windows, everything else to the default slave.
module axi_rd_decoder
  import axi_pkg::*;
#(
  parameter logic [ADDR_W-1:0] S0_BASE  = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] S1_BASE  = 32'h0001_0000,
  parameter logic [ADDR_W-1:0] WIN_MASK = 32'hFFFF_0000
) (
  input  logic [ADDR_W-1:0] addr,
  output tgt_e              target
);

  // Window compare; slave 0 takes precedence on overlapping windows
  always_comb begin
    target = TGT_SD;
    if ((addr & WIN_MASK) == S0_BASE) begin
      target = TGT_S0;
    end else if ((addr & WIN_MASK) == S1_BASE) begin
      target = TGT_S1;
    end
  end

endmodule

// File: rtl/axi_read_router.sv
// Two-master, three-slave AXI read router with one transaction in flight.
module axi_read_router
  import axi_pkg::*;
#(
  parameter logic [ADDR_W-1:0] S0_BASE  = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] S1_BASE  = 32'h0001_0000,
  parameter logic [ADDR_W-1:0] WIN_MASK = 32'hFFFF_0000
) (
  input  logic  clk,
  input  logic  rst,
  input  ar_m_t ar_m0_i,
  input  logic  arvalid_m0_i,
  output logic  arready_m0_o,
  input  ar_m_t ar_m1_i,
  input  logic  arvalid_m1_i,
  output logic  arready_m1_o,
  output r_m_t  r_m0_o,
  output logic  rvalid_m0_o,
  input  logic  rready_m0_i,
  output r_m_t  r_m1_o,
  output logic  rvalid_m1_o,
  input  logic  rready_m1_i,
  output ar_s_t ar_s0_o,
  output logic  arvalid_s0_o,
  input  logic  arready_s0_i,
  output ar_s_t ar_s1_o,
  output logic  arvalid_s1_o,
  input  logic  arready_s1_i,
  output ar_s_t ar_sd_o,
  output logic  arvalid_sd_o,
  input  logic  arready_sd_i,
  input  r_s_t  r_s0_i,
  input  logic  rvalid_s0_i,
  output logic  rready_s0_o,
  input  r_s_t  r_s1_i,
  input  logic  rvalid_s1_i,
  output logic  rready_s1_o,
  input  r_s_t  r_sd_i,
  input  logic  rvalid_sd_i,
  output logic  rready_sd_o
);

  fsm_e  state, state_next;
  logic  owner, owner_next;
  logic  pri, pri_next;
  tgt_e  target, target_next;

  logic  grant;
  ar_m_t ar_grant;
  tgt_e  dec_target;

  logic  own_arvalid;
  logic  own_rready;
  ar_m_t own_ar;
  logic  tgt_arready;
  logic  tgt_rvalid;
  r_s_t  tgt_r;
  ar_s_t ar_fwd;
  r_m_t  r_fwd;
  logic  unused_rid_hi;

  // Round-robin pick: a lone requester wins, a tie goes to pri
  assign grant    = (arvalid_m0_i && arvalid_m1_i) ? pri : arvalid_m1_i;
  assign ar_grant = grant ? ar_m1_i : ar_m0_i;

  axi_rd_decoder #(
    .S0_BASE (S0_BASE),
    .S1_BASE (S1_BASE),
    .WIN_MASK(WIN_MASK)
  ) u_decoder (
    .addr  (ar_grant.addr),
    .target(dec_target)
  );

  assign own_arvalid = owner ? arvalid_m1_i : arvalid_m0_i;
  assign own_rready  = owner ? rready_m1_i : rready_m0_i;
  assign own_ar      = owner ? ar_m1_i : ar_m0_i;

  // Master id widened with the owner index so the slave sees a unique id
  assign ar_fwd = '{id: {PFX_W'(owner), own_ar.id}, addr: own_ar.addr,
                    len: own_ar.len, size: own_ar.size, burst: own_ar.burst};
  assign r_fwd  = '{id: tgt_r.id[ID_M_W-1:0], data: tgt_r.data,
                    resp: tgt_r.resp, last: tgt_r.last};
  assign unused_rid_hi = ^tgt_r.id[ID_S_W-1:ID_M_W];

  // Select handshake inputs of the latched target slave
  always_comb begin
    tgt_arready = 1'b0;
    tgt_rvalid  = 1'b0;
    tgt_r       = '0;
    case (target)
      TGT_S0: begin
        tgt_arready = arready_s0_i;
        tgt_rvalid  = rvalid_s0_i;
        tgt_r       = r_s0_i;
      end
      TGT_S1: begin
        tgt_arready = arready_s1_i;
        tgt_rvalid  = rvalid_s1_i;
        tgt_r       = r_s1_i;
      end
      default: begin
        tgt_arready = arready_sd_i;
        tgt_rvalid  = rvalid_sd_i;
        tgt_r       = r_sd_i;
      end
    endcase
  end

  // State, owner, target and round-robin pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      owner  <= 1'b0;
      target <= TGT_S0;
      pri    <= 1'b0;
    end else begin
      state  <= state_next;
      owner  <= owner_next;
      target <= target_next;
      pri    <= pri_next;
    end
  end

  // Next-state: grant in IDLE, AR handshake ends ADDR, last R beat ends DATA
  always_comb begin
    state_next  = state;
    owner_next  = owner;
    target_next = target;
    pri_next    = pri;
    case (state)
      ST_IDLE: begin
        if (arvalid_m0_i || arvalid_m1_i) begin
          state_next  = ST_ADDR;
          owner_next  = grant;
          target_next = dec_target;
        end
      end
      ST_ADDR: begin
        if (own_arvalid && tgt_arready) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tgt_rvalid && own_rready && tgt_r.last) begin
          state_next = ST_IDLE;
          pri_next   = ~owner;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs: connect owner and target combinationally, everything else held at 0
  always_comb begin
    arready_m0_o = 1'b0;
    arready_m1_o = 1'b0;
    rvalid_m0_o  = 1'b0;
    rvalid_m1_o  = 1'b0;
    r_m0_o       = '0;
    r_m1_o       = '0;
    arvalid_s0_o = 1'b0;
    arvalid_s1_o = 1'b0;
    arvalid_sd_o = 1'b0;
    ar_s0_o      = '0;
    ar_s1_o      = '0;
    ar_sd_o      = '0;
    rready_s0_o  = 1'b0;
    rready_s1_o  = 1'b0;
    rready_sd_o  = 1'b0;
    case (state)
      ST_ADDR: begin
        case (target)
          TGT_S0: begin
            arvalid_s0_o = own_arvalid;
            ar_s0_o      = ar_fwd;
          end
          TGT_S1: begin
            arvalid_s1_o = own_arvalid;
            ar_s1_o      = ar_fwd;
          end
          default: begin
            arvalid_sd_o = own_arvalid;
            ar_sd_o      = ar_fwd;
          end
        endcase
        if (owner) arready_m1_o = tgt_arready;
        else       arready_m0_o = tgt_arready;
      end
      ST_DATA: begin
        case (target)
          TGT_S0:  rready_s0_o = own_rready;
          TGT_S1:  rready_s1_o = own_rready;
          default: rready_sd_o = own_rready;
        endcase
        if (owner) begin
          rvalid_m1_o = tgt_rvalid;
          r_m1_o      = r_fwd;
        end else begin
          rvalid_m0_o = tgt_rvalid;
          r_m0_o      = r_fwd;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_read_router.sv
// Directed self-checking bench for axi_read_router.
module tb_axi_read_router;
  import axi_pkg::*;

  logic  clk;
  logic  rst;

  ar_m_t arm   [2];
  logic  arv_m [2];
  logic  arr_m [2];
  r_m_t  rm    [2];
  logic  rv_m  [2];
  logic  rr_m  [2];

  ar_s_t ars   [3];
  logic  arv_s [3];
  logic  arr_s [3];
  r_s_t  rs    [3];
  logic  rv_s  [3];
  logic  rr_s  [3];

  int tests;
  int fails;
  int beats [2];

  axi_read_router dut (
    .clk         (clk),
    .rst         (rst),
    .ar_m0_i     (arm[0]),
    .arvalid_m0_i(arv_m[0]),
    .arready_m0_o(arr_m[0]),
    .ar_m1_i     (arm[1]),
    .arvalid_m1_i(arv_m[1]),
    .arready_m1_o(arr_m[1]),
    .r_m0_o      (rm[0]),
    .rvalid_m0_o (rv_m[0]),
    .rready_m0_i (rr_m[0]),
    .r_m1_o      (rm[1]),
    .rvalid_m1_o (rv_m[1]),
    .rready_m1_i (rr_m[1]),
    .ar_s0_o     (ars[0]),
    .arvalid_s0_o(arv_s[0]),
    .arready_s0_i(arr_s[0]),
    .ar_s1_o     (ars[1]),
    .arvalid_s1_o(arv_s[1]),
    .arready_s1_i(arr_s[1]),
    .ar_sd_o     (ars[2]),
    .arvalid_sd_o(arv_s[2]),
    .arready_sd_i(arr_s[2]),
    .r_s0_i      (rs[0]),
    .rvalid_s0_i (rv_s[0]),
    .rready_s0_o (rr_s[0]),
    .r_s1_i      (rs[1]),
    .rvalid_s1_i (rv_s[1]),
    .rready_s1_o (rr_s[1]),
    .r_sd_i      (rs[2]),
    .rvalid_sd_i (rv_s[2]),
    .rready_sd_o (rr_s[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completed R beats at each master, sampled mid-cycle
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rv_m[i] === 1'b1 && rr_m[i] === 1'b1) beats[i] = beats[i] + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] busy();
    return {arr_m[0], arr_m[1], rv_m[0], rv_m[1],
            arv_s[0], arv_s[1], arv_s[2], rr_s[0], rr_s[1], rr_s[2]};
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      arm[i] = '0; arv_m[i] = 1'b0; rr_m[i] = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      arr_s[i] = 1'b0; rs[i] = '0; rv_s[i] = 1'b0;
    end
  endtask

  task automatic set_req(input int m, input logic [3:0] id, input logic [31:0] addr, input int len);
    arm[m]   = '{id: id, addr: addr, len: 8'(len), size: 3'd2, burst: 2'b01};
    arv_m[m] = 1'b1;
  endtask

  // One read from master m to slave t; optional 5-cycle rready stall or reset at a beat
  task automatic do_read(input int m, input logic [3:0] id, input logic [31:0] addr,
                         input int len, input int t, input int stall_at, input int abort_at);
    int          b0;
    logic [31:0] d;
    set_req(m, id, addr, len);
    #1;
    chk("idle_no_handshake", 64'(busy()), 64'd0);
    tick();
    arr_s[t] = 1'b1;
    #1;
    chk("arvalid_target", 64'(arv_s[t]), 64'd1);
    chk("arvalid_onehot", 64'(int'(arv_s[0]) + int'(arv_s[1]) + int'(arv_s[2])), 64'd1);
    chk("arid", 64'(ars[t].id), 64'({4'(m), id}));
    chk("araddr", 64'(ars[t].addr), 64'(addr));
    chk("arlen", 64'(ars[t].len), 64'(len));
    chk("arready_owner", 64'(arr_m[m]), 64'd1);
    chk("arready_other", 64'(arr_m[1-m]), 64'd0);
    tick();
    arv_m[m] = 1'b0;
    arm[m]   = '0;
    arr_s[t] = 1'b0;
    rr_m[m]  = 1'b1;
    b0       = beats[m];
    for (int b = 0; b <= len; b++) begin
      d = (t == 2) ? 32'd0 : ({addr[15:0], 16'(b)} ^ 32'hA5A5_0000);
      rs[t]   = '{id: {4'(m), id}, data: d, resp: (t == 2) ? 2'b11 : 2'b00, last: (b == len)};
      rv_s[t] = 1'b1;
      if (b == abort_at) begin
        rst = 1'b1;
        #1;
        chk("rst_drops_valids", 64'(busy()), 64'd0);
        chk("rst_r_payload", 64'(rm[m]), 64'd0);
        clear_inputs();
        tick();
        rst = 1'b0;
        return;
      end
      if (b == stall_at) begin
        rr_m[m] = 1'b0;
        for (int s = 0; s < 5; s++) begin
          #1;
          chk("stall_rready_s", 64'(rr_s[t]), 64'd0);
          chk("stall_rvalid_m", 64'(rv_m[m]), 64'd1);
          chk("stall_rdata", 64'(rm[m].data), 64'(d));
          tick();
        end
        rr_m[m] = 1'b1;
      end
      #1;
      chk("rvalid_m", 64'(rv_m[m]), 64'd1);
      chk("rready_s", 64'(rr_s[t]), 64'd1);
      chk("rid", 64'(rm[m].id), 64'(id));
      chk("rdata", 64'(rm[m].data), 64'(d));
      chk("rresp", 64'(rm[m].resp), (t == 2) ? 64'd3 : 64'd0);
      chk("rlast", 64'(rm[m].last), 64'(b == len));
      tick();
    end
    rv_s[t] = 1'b0;
    rs[t]   = '0;
    rr_m[m] = 1'b0;
    #1;
    chk("back_to_idle", 64'(busy()), 64'd0);
    chk("beat_count", 64'(beats[m] - b0), 64'(len + 1));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    beats[0] = 0;
    beats[1] = 0;
    rst      = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valids", 64'(busy()), 64'd0);
    chk("reset_ar_s0", 64'(ars[0]), 64'd0);
    chk("reset_ar_sd", 64'(ars[2]), 64'd0);
    chk("reset_r_m0", 64'(rm[0]), 64'd0);
    chk("reset_r_m1", 64'(rm[1]), 64'd0);
    rst = 1'b0;
    tick();

    // M0 alone, 4-beat burst to slave 0
    do_read(0, 4'h5, 32'h0000_0040, 3, 0, -1, -1);

    // From reset, simultaneous requests: M0 first, M1 after
    pulse_reset();
    set_req(1, 4'hA, 32'h0001_0000, 1);
    do_read(0, 4'h3, 32'h0000_FFFC, 0, 0, -1, -1);
    do_read(1, 4'hA, 32'h0001_0000, 1, 1, -1, -1);

    // M0 alone with a 5-cycle master stall on beat 1
    do_read(0, 4'h7, 32'h0000_0100, 3, 0, 1, -1);

    // Pointer now favours M1: it wins the tie and hits the default slave
    set_req(0, 4'h2, 32'h0001_0004, 0);
    do_read(1, 4'hC, 32'h0002_0000, 1, 2, -1, -1);
    do_read(0, 4'h2, 32'h0001_0004, 0, 1, -1, -1);

    // Reset during beat 2 of a len-7 read, then a clean M1 read
    do_read(0, 4'h1, 32'h0000_0400, 7, 0, -1, 2);
    chk("post_reset_idle", 64'(busy()), 64'd0);
    do_read(1, 4'h9, 32'h0000_0200, 2, 0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
